ta_cap_sched: RTL

TA_CAP_SCHED -- requirements
Module: ta_cap_sched

---
 rtl/ta_cap_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ta_cap_sched.sv
// Laser capture sequencer: trigger edge -> per shot {wait lddr_rdy, fire, delay, merge window, gap}.
// Outputs are registered from the next state (one cycle after the deciding edge); lddr_rdy stalls ARM up to TO_CYC cycles.
module ta_cap_sched #(
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8,
    parameter int TO_CYC = 1024
) (
    input  logic             clk200,
    input  logic             rst,
    input  logic             cap_trig,
    input  logic             cap_abort,
    input  logic [CNT_W-1:0] cfg_dly,
    input  logic [CNT_W-1:0] cfg_win,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_rep,
    input  logic             lddr_rdy,
    output logic             ldd_trig,
    output logic             merge_en,
    output logic             capr_rdy,
    output logic             cap_cmpt,
    output logic [2:0]       cap_phase,
    output logic [REP_W-1:0] shot_cnt,
    output logic             err_to
);
    localparam int WT_W = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        FIRE   = 3'd2,
        DELAY  = 3'd3,
        WINDOW = 3'd4,
        GAP    = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, dly_q, win_q, gap_q;
    logic [REP_W-1:0] rep_q;
    logic [WT_W-1:0]  wait_cnt;
    logic [REP_W:0]   shot_inc;
    logic             trig_q, trig_arm, trig_edge, accept, timeout, win_last;

    // trig_arm blocks a trigger that was already high when reset released
    assign trig_edge = cap_trig & ~trig_q & trig_arm;
    assign accept    = (state == IDLE) & trig_edge & ~cap_abort;
    assign timeout   = (state == ARM) & ~lddr_rdy & (wait_cnt == WT_W'(TO_CYC - 1));
    assign win_last  = (state == WINDOW) & (cnt == win_q - 1'b1);
    assign shot_inc  = {1'b0, shot_cnt} + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ARM;
            ARM: begin
                if (lddr_rdy)     state_nxt = FIRE;
                else if (timeout) state_nxt = IDLE;
            end
            FIRE:    state_nxt = (dly_q == '0) ? WINDOW : DELAY;
            DELAY:   if (cnt == dly_q - 1'b1) state_nxt = WINDOW;
            WINDOW: begin
                if (win_last) begin
                    if (shot_inc == {1'b0, rep_q}) state_nxt = DONE;
                    else if (gap_q == '0)          state_nxt = ARM;
                    else                           state_nxt = GAP;
                end
            end
            GAP:     if (cnt == gap_q - 1'b1) state_nxt = ARM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cap_abort && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk200 or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            trig_arm  <= 1'b0;
            cnt       <= '0;
            wait_cnt  <= '0;
            dly_q     <= '0;
            win_q     <= '0;
            gap_q     <= '0;
            rep_q     <= '0;
            shot_cnt  <= '0;
            err_to    <= 1'b0;
            ldd_trig  <= 1'b0;
            merge_en  <= 1'b0;
            cap_cmpt  <= 1'b0;
            capr_rdy  <= 1'b1;
            cap_phase <= 3'd0;
        end else begin
            state  <= state_nxt;
            trig_q <= cap_trig;
            if (!cap_trig) trig_arm <= 1'b1;

            // phase counter restarts on every state change and saturates otherwise
            cnt      <= (state_nxt != state) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
            wait_cnt <= (state == ARM && state_nxt == ARM) ? wait_cnt + 1'b1 : '0;

            if (accept) begin
                dly_q    <= cfg_dly;
                win_q    <= (cfg_win == '0) ? CNT_W'(1) : cfg_win;
                gap_q    <= cfg_gap;
                rep_q    <= (cfg_rep == '0) ? REP_W'(1) : cfg_rep;
                shot_cnt <= '0;
                err_to   <= 1'b0;
            end
            if (win_last && !cap_abort && shot_cnt != '1) shot_cnt <= shot_inc[REP_W-1:0];
            if (timeout && !cap_abort) err_to <= 1'b1;

            ldd_trig  <= (state_nxt == FIRE);
            merge_en  <= (state_nxt == WINDOW);
            cap_cmpt  <= (state_nxt == DONE);
            capr_rdy  <= (state_nxt == IDLE);
            cap_phase <= state_nxt;
        end
    end
endmodule
